// File: rtl/cycle_stats_collector_if.sv
// Host readout stream for cycle_stats_collector: a valid/ready channel
// carrying one buffered cycle-count sample per transfer.
interface cycle_stats_collector_if #(
  parameter int CNT_W = 32
) ();
  logic             m_valid;
  logic             m_ready;
  logic [CNT_W-1:0] m_data;

  // Collector side drives the stream.
  modport master (
    output m_valid,
    output m_data,
    input  m_ready
  );

  // Host side consumes the stream.
  modport slave (
    input  m_valid,
    input  m_data,
    output m_ready
  );
endinterface

// File: rtl/cycle_stats_collector.sv
// cycle_stats_collector: buffers cycle-count result pulses in a
// first-word-fall-through FIFO for host readout and keeps running
// statistics (count, min, max, saturating sum).
//
// Optional feature macro: CYCLE_STATS_AVG_EN
//   When defined, adds avg_req/avg_value/avg_valid and a restoring
//   divider FSM that reports floor(stat_sum / stat_num).
module cycle_stats_collector #(
  parameter int CNT_W = 32,
  parameter int DEPTH = 16,
  parameter int SUM_W = 48
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     sample_valid,
  input  logic [CNT_W-1:0]         sample_count,
  input  logic                     clear,
  cycle_stats_collector_if.master  m_if,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     overflow,
  output logic [31:0]              stat_num,
  output logic [CNT_W-1:0]         stat_min,
  output logic [CNT_W-1:0]         stat_max,
`ifdef CYCLE_STATS_AVG_EN
  input  logic                     avg_req,
  output logic [CNT_W-1:0]         avg_value,
  output logic                     avg_valid,
`endif
  output logic [SUM_W-1:0]         stat_sum
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  // Saturating add of a zero-extended sample into the running sum.
  function automatic logic [SUM_W-1:0] sat_add_sum(input logic [SUM_W-1:0] acc,
                                                   input logic [CNT_W-1:0] smp);
    logic [SUM_W:0] t;
    t = {1'b0, acc} + {{(SUM_W + 1 - CNT_W){1'b0}}, smp};
    return t[SUM_W] ? {SUM_W{1'b1}} : t[SUM_W-1:0];
  endfunction

  // Saturating increment of the sample counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] n);
    return (n == 32'hFFFF_FFFF) ? n : n + 32'd1;
  endfunction

  logic [CNT_W-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr;
  logic             full, empty, pop, push, drop;
  logic             vld_p0;
  logic [31:0]      num_p1;
  logic [CNT_W-1:0] min_p1, max_p1;
  logic [SUM_W-1:0] sum_p1;
  logic             ovf_p1;

  // ---- stage 0: qualify the incoming sample against clear and FIFO state
  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop    = m_if.m_valid && m_if.m_ready;
  assign vld_p0 = sample_valid && !clear;
  assign push   = vld_p0 && (!full || pop);
  assign drop   = vld_p0 && full && !pop;

  assign m_if.m_valid = !empty;
  assign m_if.m_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];
  assign fifo_level   = wr_ptr - rd_ptr;

  // Sample storage; contents are only observed through the gated head.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= sample_count;
  end

  // Read/write pointers with an extra wrap bit to separate full from empty.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // ---- stage 1: statistics and sticky overflow, one cycle after the sample
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      num_p1 <= '0;
      min_p1 <= '1;
      max_p1 <= '0;
      sum_p1 <= '0;
      ovf_p1 <= 1'b0;
    end else begin
      if (vld_p0) begin
        num_p1 <= sat_inc(num_p1);
        if (sample_count < min_p1) min_p1 <= sample_count;
        if (sample_count > max_p1) max_p1 <= sample_count;
        sum_p1 <= sat_add_sum(sum_p1, sample_count);
      end
      if (drop) ovf_p1 <= 1'b1;
    end
  end

  assign stat_num = num_p1;
  assign stat_min = min_p1;
  assign stat_max = max_p1;
  assign stat_sum = sum_p1;
  assign overflow = ovf_p1;

`ifdef CYCLE_STATS_AVG_EN
  localparam int CW = (SUM_W > 1) ? $clog2(SUM_W) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SUM_W - 1);

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} avg_state_t;

  // Clamp a full-width quotient into the sample width.
  function automatic logic [CNT_W-1:0] clamp_q(input logic [SUM_W-1:0] q);
    return (|q[SUM_W-1:CNT_W]) ? {CNT_W{1'b1}} : q[CNT_W-1:0];
  endfunction

  avg_state_t       state, state_nxt;
  logic             load_snap, step_div;
  logic [CW-1:0]    cnt;
  logic [SUM_W-1:0] quo_q, quo_nxt;
  logic [31:0]      rem_q, rem_nxt, div_q;
  logic [32:0]      rem_sh, rem_diff;
  logic [CNT_W-1:0] avg_q;

  // Average FSM state register; clear aborts any division in flight.
  always_ff @(posedge clk) begin
    if (reset || clear) state <= IDLE;
    else                state <= state_nxt;
  end

  // Average FSM next-state and control decode.
  always_comb begin
    state_nxt = state;
    load_snap = 1'b0;
    step_div  = 1'b0;
    avg_valid = 1'b0;
    case (state)
      IDLE: begin
        if (avg_req) begin
          load_snap = 1'b1;
          state_nxt = (num_p1 == 32'd0) ? DONE : DIVIDE;
        end
      end
      DIVIDE: begin
        step_div = 1'b1;
        if (cnt == CNT_LAST) state_nxt = DONE;
      end
      DONE: begin
        avg_valid = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh   = {rem_q, quo_q[SUM_W-1]};
    rem_diff = rem_sh - {1'b0, div_q};
    quo_nxt  = {quo_q[SUM_W-2:0], 1'b0};
    rem_nxt  = rem_sh[31:0];
    if (rem_sh >= {1'b0, div_q}) begin
      quo_nxt[0] = 1'b1;
      rem_nxt    = rem_diff[31:0];
    end
  end

  // Divider datapath: snapshot on request, iterate, latch the clamped result.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt   <= '0;
      avg_q <= '0;
    end else if (load_snap) begin
      quo_q <= sum_p1;
      div_q <= num_p1;
      rem_q <= '0;
      cnt   <= '0;
      if (num_p1 == 32'd0) avg_q <= '0;
    end else if (step_div) begin
      quo_q <= quo_nxt;
      rem_q <= rem_nxt;
      cnt   <= cnt + {{(CW-1){1'b0}}, 1'b1};
      if (cnt == CNT_LAST) avg_q <= clamp_q(quo_nxt);
    end
  end

  assign avg_value = avg_q;
`endif

endmodule

// File: tb/tb_cycle_stats_collector.sv
// Scoreboard bench for cycle_stats_collector: expected FIFO contents are
// queued as samples are accepted and compared as the host pops them;
// statistics are tracked by a reference model.
module tb_cycle_stats_collector;
  localparam int CNT_W = 32;
  localparam int DEPTH = 16;
  localparam int SUM_W = 48;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   sample_valid;
  logic [CNT_W-1:0]       sample_count;
  logic                   clear;
  logic [$clog2(DEPTH):0] fifo_level;
  logic                   overflow;
  logic [31:0]            stat_num;
  logic [CNT_W-1:0]       stat_min, stat_max;
  logic [SUM_W-1:0]       stat_sum;
`ifdef CYCLE_STATS_AVG_EN
  logic                   avg_req;
  logic [CNT_W-1:0]       avg_value;
  logic                   avg_valid;
`endif

  cycle_stats_collector_if #(.CNT_W(CNT_W)) s_if ();

  cycle_stats_collector #(.CNT_W(CNT_W), .DEPTH(DEPTH), .SUM_W(SUM_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .sample_valid (sample_valid),
    .sample_count (sample_count),
    .clear        (clear),
    .m_if         (s_if),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .stat_num     (stat_num),
    .stat_min     (stat_min),
    .stat_max     (stat_max),
`ifdef CYCLE_STATS_AVG_EN
    .avg_req      (avg_req),
    .avg_value    (avg_value),
    .avg_valid    (avg_valid),
`endif
    .stat_sum     (stat_sum)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  logic [CNT_W-1:0] sb [$];
  logic [31:0]      e_num;
  logic [CNT_W-1:0] e_min, e_max;
  logic [SUM_W-1:0] e_sum;
  logic             e_ovf;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_idle();
    sb.delete();
    e_num = '0;
    e_min = '1;
    e_max = '0;
    e_sum = '0;
    e_ovf = 1'b0;
  endtask

  task automatic model_sample(input logic [CNT_W-1:0] v);
    logic [SUM_W:0] t;
    if (e_num != 32'hFFFF_FFFF) e_num = e_num + 32'd1;
    if (v < e_min) e_min = v;
    if (v > e_max) e_max = v;
    t = {1'b0, e_sum} + (SUM_W + 1)'(v);
    e_sum = t[SUM_W] ? '1 : t[SUM_W-1:0];
  endtask

  // One clock of stimulus; pops are checked against the scoreboard head.
  task automatic cyc(input bit sv, input logic [CNT_W-1:0] val, input bit rdy, input bit clr);
    sample_valid = sv;
    sample_count = val;
    s_if.m_ready = rdy;
    clear        = clr;
    if (rdy && sb.size() > 0) begin
      chk("pop_valid", 64'(s_if.m_valid), 64'(1));
      chk("pop_data", 64'(s_if.m_data), 64'(sb[0]));
      void'(sb.pop_front());
    end
    if (clr) begin
      model_idle();
    end else if (sv) begin
      if (sb.size() < DEPTH) sb.push_back(val);
      else                   e_ovf = 1'b1;
      model_sample(val);
    end
    tick();
    sample_valid = 1'b0;
    clear        = 1'b0;
    s_if.m_ready = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_mvalid"}, 64'(s_if.m_valid), 64'(sb.size() > 0));
    chk({tag, "_level"}, 64'(fifo_level), 64'(sb.size()));
    chk({tag, "_ovf"}, 64'(overflow), 64'(e_ovf));
    chk({tag, "_num"}, 64'(stat_num), 64'(e_num));
    chk({tag, "_min"}, 64'(stat_min), 64'(e_min));
    chk({tag, "_max"}, 64'(stat_max), 64'(e_max));
    chk({tag, "_sum"}, 64'(stat_sum), 64'(e_sum));
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_mvalid"}, 64'(s_if.m_valid), 64'(0));
    chk({tag, "_mdata"}, 64'(s_if.m_data), 64'(0));
    chk({tag, "_level"}, 64'(fifo_level), 64'(0));
    chk({tag, "_ovf"}, 64'(overflow), 64'(0));
    chk({tag, "_num"}, 64'(stat_num), 64'(0));
    chk({tag, "_min"}, 64'(stat_min), 64'(32'hFFFF_FFFF));
    chk({tag, "_max"}, 64'(stat_max), 64'(0));
    chk({tag, "_sum"}, 64'(stat_sum), 64'(0));
  endtask

  initial begin
    reset        = 1'b1;
    sample_valid = 1'b0;
    sample_count = '0;
    clear        = 1'b0;
    s_if.m_ready = 1'b0;
`ifdef CYCLE_STATS_AVG_EN
    avg_req      = 1'b0;
`endif
    model_idle();
    tick();
    tick();
    reset = 1'b0;
    check_idle("reset");

    // Three samples held in the FIFO, then drained in order.
    cyc(1, 100, 0, 0);
    chk("latency_mvalid", 64'(s_if.m_valid), 64'(1));
    chk("latency_mdata", 64'(s_if.m_data), 64'(100));
    cyc(1, 40, 0, 0);
    cyc(1, 250, 0, 0);
    check_all("three");
    chk("three_sum_const", 64'(stat_sum), 64'(390));
    chk("three_min_const", 64'(stat_min), 64'(40));
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
    check_all("drained");

    // Overfill by one, then clear.
    cyc(0, 0, 0, 1);
    check_idle("clear0");
    for (int i = 0; i < DEPTH + 1; i++) cyc(1, 32'(i * 3 + 1), 0, 0);
    check_all("overfill");
    chk("overfill_ovf_const", 64'(overflow), 64'(1));
    chk("overfill_num_const", 64'(stat_num), 64'(17));
    cyc(0, 0, 0, 1);
    check_idle("clear1");

    // Full FIFO with simultaneous push and pop.
    for (int i = 0; i < DEPTH; i++) cyc(1, 32'(1000 + i), 0, 0);
    cyc(1, 7777, 1, 0);
    check_all("full_pushpop");
    chk("full_pushpop_ovf", 64'(overflow), 64'(0));
    for (int i = 0; i < DEPTH; i++) cyc(0, 0, 1, 0);
    check_all("full_drained");

    // clear wins over a same-cycle sample.
    cyc(1, 55, 0, 1);
    check_idle("clear_vs_sample");

    // reset together with clear.
    cyc(1, 9, 0, 0);
    reset = 1'b1;
    cyc(0, 0, 0, 1);
    reset = 1'b0;
    check_idle("reset_and_clear");

    // Random traffic including back-to-back pushes and pops.
    for (int i = 0; i < 400; i++) begin
      cyc(bit'($urandom_range(0, 3) != 0), 32'($urandom_range(1, 5000)),
          bit'($urandom_range(0, 2) == 0), bit'(i == 250));
      chk("rand_mvalid", 64'(s_if.m_valid), 64'(sb.size() > 0));
      chk("rand_level", 64'(fifo_level), 64'(sb.size()));
    end
    check_all("random");

    // Sum saturation at all-ones of SUM_W.
    cyc(0, 0, 0, 1);
    for (int i = 0; i < 65536; i++) cyc(1, 32'hFFFF_FFFF, 0, 0);
    chk("sum_presat", 64'(stat_sum), 64'(48'hFFFF_FFFF_0000));
    cyc(1, 32'hFFFF_FFFF, 0, 0);
    chk("sum_sat", 64'(stat_sum), 64'(48'hFFFF_FFFF_FFFF));
    check_all("sat");

`ifdef CYCLE_STATS_AVG_EN
    begin
      int n;
      cyc(0, 0, 0, 1);
      cyc(1, 10, 0, 0);
      cyc(1, 20, 0, 0);
      cyc(1, 31, 0, 0);
      avg_req = 1'b1;
      tick();
      avg_req = 1'b0;
      n = 0;
      while (!avg_valid && n < 200) begin
        tick();
        n++;
      end
      chk("avg_latency", 64'(n), 64'(48));
      chk("avg_value", 64'(avg_value), 64'(20));
      tick();
      chk("avg_pulse", 64'(avg_valid), 64'(0));
      cyc(0, 0, 0, 1);
      avg_req = 1'b1;
      tick();
      avg_req = 1'b0;
      chk("avg_zero_valid", 64'(avg_valid), 64'(1));
      chk("avg_zero_value", 64'(avg_value), 64'(0));
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/cycle_stats_collector.md
Name: cycle_stats_collector

Overview:
- Consumer side of the cycle-count measurement interface. Takes each count_valid/cycle_count result pulse produced by a cycle counter and buffers it in a FIFO for host readout over a valid/ready stream.
- Keeps running statistics (sample count, min, max, sum) for benchmark reporting in accelerator apps such as sha2.

Parameters:
- CNT_W, 32, width of each cycle-count sample.
- DEPTH, 16, FIFO depth in samples; power of two, 2 to 256.
- SUM_W, 48, width of the accumulated sum.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous active-high reset
- sample_valid  in  1  one-cycle pulse, sample_count is valid
- sample_count  in  CNT_W  measured elapsed cycles
- clear  in  1  pulse; flush FIFO and statistics
- m_valid  out  1  FIFO head available
- m_ready  in  1  host accepts head
- m_data  out  CNT_W  FIFO head sample
- fifo_level  out  $clog2(DEPTH)+1  occupancy, 0 to DEPTH
- overflow  out  1  sticky: a sample was dropped because the FIFO was full
- stat_num  out  32  samples seen, saturating
- stat_min  out  CNT_W  smallest sample
- stat_max  out  CNT_W  largest sample
- stat_sum  out  SUM_W  sum of samples, saturating

Behaviour:
- Reset, and also clear, return every output to its idle value:
  - m_valid=0, m_data=0, fifo_level=0, overflow=0.
  - stat_num=0, stat_min=all-ones, stat_max=0, stat_sum=0.
  - FIFO pointers are zeroed.
  - If reset and clear are both asserted, reset wins; the end state is identical.
- clear takes priority over a sample_valid in the same cycle. That sample is discarded and not counted.
- Push:
  - A sample_valid while the FIFO is not full, or while it is full but a pop happens in the same cycle, writes sample_count at the tail.
  - Sample to m_valid latency: 1 cycle. The registered write makes m_valid=1 the cycle after sample_valid on an empty FIFO.
- Drop: sample_valid with the FIFO full and no pop in that cycle discards the sample. overflow goes to 1 next cycle and stays set until reset or clear.
- Pop: m_valid && m_ready advances the head.
  - The FIFO is first-word-fall-through: m_data always shows the head entry while m_valid=1.
  - m_data is don't-care while m_valid=0, but must not contain X after reset.
- Simultaneous push and pop:
  - Level is unchanged and no overflow is flagged.
  - On an empty FIFO with m_valid=0 no pop is possible, so the push simply lands.
- fifo_level tracks the registered occupancy and wraps correctly across pointer wrap. The pointers carry an extra MSB to tell full from empty.
- Statistics update one cycle after every sample_valid that is not cancelled by clear, including dropped samples:
  - stat_num increments and saturates at 0xFFFFFFFF.
  - stat_min = min(stat_min, sample); stat_max = max(stat_max, sample).
  - stat_sum adds the zero-extended sample and saturates at all-ones of SUM_W.
- m_ready while m_valid=0 is ignored.
- sample_valid held high on consecutive cycles means one sample per cycle. Back-to-back pushes at full rate must be supported.

Optional Feature:
- Macro CYCLE_STATS_AVG_EN.
- Defined: adds input avg_req (1-bit pulse), output avg_value (CNT_W) and output avg_valid (1-bit pulse).
  - A small FSM with states IDLE, DIVIDE and DONE computes floor(stat_sum / stat_num) with a restoring divider, one quotient bit per cycle, SUM_W cycles.
  - avg_req is accepted only in IDLE; it snapshots sum and num and enters DIVIDE.
  - After SUM_W cycles the FSM enters DONE. There avg_value holds the quotient, clamped to all-ones of CNT_W, and avg_valid pulses for 1 cycle before returning to IDLE.
  - If stat_num=0, avg_value=0 and avg_valid pulses the cycle after avg_req.
  - avg_req in DIVIDE or DONE is ignored.
  - clear or reset aborts to IDLE with avg_valid=0 and avg_value=0.
- Undefined: those ports and the FSM do not exist. All other behaviour is identical.

Test Plan:
- Samples 100, 40, 250 with m_ready=0 -> fifo_level=3, stat_num=3, stat_min=40, stat_max=250, stat_sum=390. Then m_ready=1 -> m_data 100, 40, 250 in order, m_valid=0 afterwards.
- DEPTH=16: push 17 samples with m_ready=0 -> fifo_level=16, overflow=1, stat_num=17. Pulse clear -> all outputs at reset values next cycle.
- FIFO full plus sample_valid and m_valid && m_ready in the same cycle -> fifo_level stays 16, overflow stays 0, new sample becomes tail.
- SUM_W=48: samples 0xFFFFFFFF repeated 2^16+1 times -> stat_sum saturates at 0xFFFFFFFFFFFF with no wrap.
- clear and sample_valid(55) in the same cycle -> stat_num=0, fifo_level=0, stat_min=all-ones.
- With CYCLE_STATS_AVG_EN: samples 10, 20, 31 then avg_req -> avg_valid after 48 cycles with avg_value=20. avg_req with stat_num=0 -> avg_value=0, avg_valid the next cycle.
